// File: rtl/clk_div_pkg.sv
// Shared types, constants and configuration clamping for the clk_div_gen clock generator.
package clk_div_pkg;

    localparam int unsigned CNT_W_DEF = 8;
    // Config fields are carried at this fixed width; CNT_W must not exceed it.
    localparam int unsigned CFG_W     = 16;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic             en;
        logic             jit;
        logic [CFG_W-1:0] period;
        logic [CFG_W-1:0] high;
    } ch_cfg_t;

    function automatic ch_cfg_t clamp_cfg(input logic en, input logic jit,
                                          input logic [CFG_W-1:0] period,
                                          input logic [CFG_W-1:0] high);
        ch_cfg_t c;
        c.en     = en;
        c.jit    = jit;
        c.period = (period < CFG_W'(2)) ? CFG_W'(2) : period;
        c.high   = (high == '0) ? CFG_W'(1) : high;
        if (c.high >= c.period)
            c.high = c.period - 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One clk_div_gen channel: OFF/RUN state, period counter, shadow config and registered outputs.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    acc,
    input  ch_cfg_t cfg,
    input  logic    lfsr_bit,
    output logic    clk_out,
    output logic    tick,
    output logic    pending
);

    typedef enum logic {ST_OFF, ST_RUN} state_t;

    state_t           state;
    ch_cfg_t          act;
    ch_cfg_t          shadow;
    ch_cfg_t          nxt;
    logic [CNT_W-1:0] cnt;
    logic             jbit;
    logic [CFG_W:0]   cnt_x;
    logic [CFG_W:0]   p_last;
    logic             boundary;

    always_comb begin
        cnt_x    = (CFG_W+1)'(cnt);
        p_last   = {1'b0, act.period} + (CFG_W+1)'(jbit) - (CFG_W+1)'(1);
        boundary = (state == ST_RUN) && (cnt_x == p_last);
        nxt      = pending ? shadow : act;
    end

    // Outputs are decoded from the next counter value so they line up with cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_OFF;
            act     <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            cnt     <= '0;
            jbit    <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    if (acc) begin
                        act <= cfg;
                        if (cfg.en) begin
                            state   <= ST_RUN;
                            cnt     <= '0;
                            jbit    <= 1'b0;
                            pending <= 1'b0;
                            clk_out <= 1'b1;
                            tick    <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (boundary) begin
                        act     <= nxt;
                        pending <= 1'b0;
                        cnt     <= '0;
                        jbit    <= nxt.jit & lfsr_bit;
                        clk_out <= nxt.en;
                        tick    <= nxt.en;
                        if (!nxt.en)
                            state <= ST_OFF;
                    end else begin
                        cnt     <= cnt + 1'b1;
                        clk_out <= (cnt_x + 1'b1) < {1'b0, act.high};
                        tick    <= 1'b0;
                    end
                    // A request landing in the boundary cycle waits for the next boundary.
                    if (acc) begin
                        shadow  <= cfg;
                        pending <= 1'b1;
                    end
                end
                default: state <= ST_OFF;
            endcase
        end
    end

endmodule

// File: rtl/clk_div_gen.sv
// clk_div_gen: NUM_CH programmable clock/strobe generators with glitch-free reconfiguration.
// Define CLKDIV_JITTER_EN to build the shared LFSR and per-channel period jitter.
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int unsigned  NUM_CH = 2,
    parameter int unsigned  CNT_W  = CNT_W_DEF,
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic              cfg_en,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic              cfg_jit,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] acc;
    logic [NUM_CH-1:0] jit_bit;
    ch_cfg_t           cfg_c;

    // Out-of-range channel numbers fall through with ready=1 and no acceptance.
    always_comb begin
        cfg_ready = 1'b1;
        acc       = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i))
                cfg_ready = ~pending[i];
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            acc[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
        end
    end

    assign cfg_c = clamp_cfg(cfg_en, cfg_jit, CFG_W'(cfg_period), CFG_W'(cfg_high));

`ifdef CLKDIV_JITTER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end

    always_comb begin
        jit_bit = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            jit_bit[i] = lfsr[4'(i % 16)];
        end
    end
`else
    assign jit_bit = '0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_ch #(.CNT_W(CNT_W)) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .acc      (acc[g]),
            .cfg      (cfg_c),
            .lfsr_bit (jit_bit[g]),
            .clk_out  (clk_out[g]),
            .tick     (tick[g]),
            .pending  (pending[g])
        );
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen against a period-level waveform model.
module tb_clk_div_gen;

    localparam int NCH = 3;
    localparam int CW  = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [1:0]     cfg_ch = '0;
    logic           cfg_en = 1'b0;
    logic [CW-1:0]  cfg_period = '0;
    logic [CW-1:0]  cfg_high = '0;
    logic           cfg_jit = 1'b0;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    clk_div_gen #(.NUM_CH(NCH), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_en     (cfg_en),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_jit    (cfg_jit),
        .clk_out    (clk_out),
        .tick       (tick)
    );

    // Model: each running channel holds a queue of {tick, clk} for the rest of its current period.
    bit       run   [NCH];
    bit       pv    [NCH];
    int       cur_p [NCH];
    int       cur_h [NCH];
    int       pnd_p [NCH];
    int       pnd_h [NCH];
    bit       pnd_en[NCH];
    bit [1:0] wave  [NCH][$];

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            run[c] = 0;
            pv[c]  = 0;
            wave[c].delete();
        end
    endtask

    task automatic gen(input int c);
        int p;
        int h;
        p = cur_p[c];
        h = cur_h[c];
        if (p < 2) p = 2;
        if (h == 0) h = 1;
        if (h >= p) h = p - 1;
        for (int i = 0; i < p; i++) wave[c].push_back({i == 0, i < h});
    endtask

    task automatic calc_exp(output logic [NCH-1:0] ec, output logic [NCH-1:0] et, output logic er);
        for (int c = 0; c < NCH; c++) begin
            if (wave[c].size() > 0) {et[c], ec[c]} = wave[c][0];
            else {et[c], ec[c]} = 2'b00;
        end
        er = 1'b1;
        if (int'(cfg_ch) < NCH) er = !pv[int'(cfg_ch)];
    endtask

    task automatic model_adv();
        bit rdy[NCH];
        bit was[NCH];
        for (int c = 0; c < NCH; c++) begin
            rdy[c] = !pv[c];
            was[c] = run[c];
        end
        for (int c = 0; c < NCH; c++) begin
            if (wave[c].size() > 0) void'(wave[c].pop_front());
            if (run[c] && wave[c].size() == 0) begin
                if (pv[c]) begin
                    cur_p[c] = pnd_p[c];
                    cur_h[c] = pnd_h[c];
                    pv[c]    = 0;
                    if (!pnd_en[c]) run[c] = 0;
                end
                if (run[c]) gen(c);
            end
            if (cfg_valid && int'(cfg_ch) == c && rdy[c]) begin
                if (was[c]) begin
                    pv[c] = 1; pnd_p[c] = int'(cfg_period); pnd_h[c] = int'(cfg_high); pnd_en[c] = cfg_en;
                end else begin
                    cur_p[c] = int'(cfg_period);
                    cur_h[c] = int'(cfg_high);
                    if (cfg_en) begin
                        run[c] = 1;
                        gen(c);
                    end
                end
            end
        end
    endtask

    task automatic step(input bit v, input int ch, input bit en, input int p, input int h, input bit j);
        @(negedge clk);
        cfg_valid  = v;
        cfg_ch     = 2'(ch);
        cfg_en     = en;
        cfg_period = CW'(p);
        cfg_high   = CW'(h);
        cfg_jit    = j;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        cfg_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            step(0, c, 0, 0, 0, 0);
            tests++;
            if (clk_out !== '0 || tick !== '0) begin
                failed++;
                $display("FAIL reset_out ch=%0d clk_out=%b tick=%b expected 0", c, clk_out, tick);
            end
            tests++;
            if (cfg_ready !== 1'b1) begin
                failed++;
                $display("FAIL reset_ready ch=%0d got %b expected 1", c, cfg_ready);
            end
        end
    endtask

    task automatic test_basic();
        logic [NCH-1:0] ec, et;
        logic er;
        logic [7:0] pat, tpat;
        pat = '0; tpat = '0;
        step(1, 0, 1, 4, 2, 0);
        model_adv();
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 0, 0, 0);
            calc_exp(ec, et, er);
            if (i < 8) begin
                pat  = {pat[6:0], clk_out[0]};
                tpat = {tpat[6:0], tick[0]};
            end
            tests++;
            if (clk_out !== ec || tick !== et || cfg_ready !== er) begin
                failed++;
                $display("FAIL basic cyc=%0d clk_out=%b tick=%b ready=%b expected %b %b %b", i, clk_out, tick, cfg_ready, ec, et, er);
            end
            model_adv();
        end
        tests++;
        if (pat !== 8'b11001100 || tpat !== 8'b10001000) begin
            failed++;
            $display("FAIL basic_pattern clk=%b tick=%b expected 11001100 10001000", pat, tpat);
        end
    endtask

    task automatic test_reconfig();
        logic [NCH-1:0] ec, et;
        logic er;
        int guard;
        guard = 0;
        while (wave[0].size() != 3 && guard < 10) begin
            step(0, 0, 0, 0, 0, 0);
            model_adv();
            guard++;
        end
        tests++;
        if (wave[0].size() != 3) begin
            failed++;
            $display("FAIL reconfig_phase got %0d expected 3", wave[0].size());
        end
        step(1, 0, 1, 5, 1, 0);
        model_adv();
        step(0, 0, 0, 0, 0, 0);
        tests++;
        if (cfg_ready !== 1'b0) begin
            failed++;
            $display("FAIL reconfig_ready got %b expected 0", cfg_ready);
        end
        model_adv();
        for (int i = 0; i < 18; i++) begin
            step(0, 0, 0, 0, 0, 0);
            calc_exp(ec, et, er);
            tests++;
            if (clk_out !== ec || tick !== et || cfg_ready !== er) begin
                failed++;
                $display("FAIL reconfig cyc=%0d clk_out=%b tick=%b ready=%b expected %b %b %b", i, clk_out, tick, cfg_ready, ec, et, er);
            end
            model_adv();
        end
    endtask

    task automatic test_clamp();
        logic [NCH-1:0] ec, et;
        logic er;
        logic [5:0] p0, p1;
        do_reset();
        step(1, 0, 1, 1, 0, 0);
        model_adv();
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, 0, 0);
            calc_exp(ec, et, er);
            p0 = {p0[4:0], clk_out[0]};
            tests++;
            if (clk_out !== ec || tick !== et) begin
                failed++;
                $display("FAIL clamp0 cyc=%0d clk_out=%b tick=%b expected %b %b", i, clk_out, tick, ec, et);
            end
            model_adv();
        end
        step(1, 1, 1, 6, 9, 0);
        model_adv();
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 0, 0, 0, 0);
            calc_exp(ec, et, er);
            if (i < 6) p1 = {p1[4:0], clk_out[1]};
            tests++;
            if (clk_out !== ec || tick !== et || cfg_ready !== er) begin
                failed++;
                $display("FAIL clamp1 cyc=%0d clk_out=%b tick=%b ready=%b expected %b %b %b", i, clk_out, tick, cfg_ready, ec, et, er);
            end
            model_adv();
        end
        tests++;
        if (p0 !== 6'b101010 || p1 !== 6'b111110) begin
            failed++;
            $display("FAIL clamp_pattern ch0=%b ch1=%b expected 101010 111110", p0, p1);
        end
    endtask

    task automatic test_disable();
        logic [NCH-1:0] ec, et;
        logic er;
        logic [11:0] pat, tpat;
        do_reset();
        step(1, 0, 1, 6, 3, 0);
        model_adv();
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0, 0, 0);
            model_adv();
        end
        while (wave[0].size() != 6) begin
            step(0, 0, 0, 0, 0, 0);
            model_adv();
        end
        step(1, 0, 0, 6, 3, 0);
        pat = '0; tpat = '0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) step(0, 0, 0, 0, 0, 0);
            calc_exp(ec, et, er);
            pat  = {pat[10:0], clk_out[0]};
            tpat = {tpat[10:0], tick[0]};
            tests++;
            if (clk_out !== ec || tick !== et || cfg_ready !== er) begin
                failed++;
                $display("FAIL disable cyc=%0d clk_out=%b tick=%b ready=%b expected %b %b %b", i, clk_out, tick, cfg_ready, ec, et, er);
            end
            model_adv();
        end
        tests++;
        if (pat !== 12'b111000000000 || tpat !== 12'b100000000000) begin
            failed++;
            $display("FAIL disable_pattern clk=%b tick=%b expected 111000000000 100000000000", pat, tpat);
        end
    endtask

    task automatic test_indep_reset();
        logic [NCH-1:0] ec, et;
        logic er;
        int guard;
        do_reset();
        step(1, 0, 1, 3, 1, 0);
        model_adv();
        step(1, 1, 1, 7, 4, 0);
        model_adv();
        for (int i = 0; i < 30; i++) begin
            step(0, i % 2, 0, 0, 0, 0);
            calc_exp(ec, et, er);
            tests++;
            if (clk_out !== ec || tick !== et || cfg_ready !== er) begin
                failed++;
                $display("FAIL indep cyc=%0d clk_out=%b tick=%b ready=%b expected %b %b %b", i, clk_out, tick, cfg_ready, ec, et, er);
            end
            model_adv();
        end
        guard = 0;
        while (!(wave[1].size() > 1 && wave[1][0][0] == 1'b1) && guard < 10) begin
            step(0, 0, 0, 0, 0, 0);
            model_adv();
            guard++;
        end
        step(0, 0, 0, 0, 0, 0);
        tests++;
        if (clk_out[1] !== 1'b1) begin
            failed++;
            $display("FAIL prereset_high got %b expected 1", clk_out[1]);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (clk_out !== '0 || tick !== '0) begin
            failed++;
            $display("FAIL async_reset clk_out=%b tick=%b expected 0", clk_out, tick);
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(0, i % 3, 0, 0, 0, 0);
            tests++;
            if (clk_out !== '0 || tick !== '0 || cfg_ready !== 1'b1) begin
                failed++;
                $display("FAIL post_reset cyc=%0d clk_out=%b tick=%b ready=%b expected 0 0 1", i, clk_out, tick, cfg_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [NCH-1:0] ec, et;
        logic er;
        int nbad;
        do_reset();
        nbad = 0;
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(3) == 0, $urandom_range(3), $urandom_range(6) != 0,
                 $urandom_range(12), $urandom_range(14), 0);
            calc_exp(ec, et, er);
            tests++;
            if (clk_out !== ec || tick !== et || cfg_ready !== er) begin
                failed++;
                if (nbad < 10)
                    $display("FAIL random cyc=%0d clk_out=%b tick=%b ready=%b expected %b %b %b", i, clk_out, tick, cfg_ready, ec, et, er);
                nbad++;
            end
            model_adv();
        end
    endtask

    task automatic test_jitter();
        int nper, len, hi, bad;
        bit started, seen4, seen5;
        nper = 0; len = 0; hi = 0; bad = 0;
        started = 0; seen4 = 0; seen5 = 0;
        do_reset();
        step(1, 0, 1, 4, 2, 1);
        for (int i = 0; i < 7000 && nper < 1000; i++) begin
            step(0, 0, 0, 0, 0, 0);
            if (tick[0] === 1'b1) begin
                if (started) begin
                    nper++;
                    if (len == 4) seen4 = 1;
                    if (len == 5) seen5 = 1;
`ifdef CLKDIV_JITTER_EN
                    if (!(len == 4 || len == 5) || hi != 2) bad++;
`else
                    if (len != 4 || hi != 2) bad++;
`endif
                end
                started = 1; len = 0; hi = 0;
            end
            len++;
            if (clk_out[0] === 1'b1) hi++;
        end
        tests++;
        if (nper != 1000) begin
            failed++;
            $display("FAIL jitter_periods got %0d expected 1000", nper);
        end
        tests++;
        if (bad != 0) begin
            failed++;
            $display("FAIL jitter_shape bad_periods=%0d expected 0", bad);
        end
        tests++;
`ifdef CLKDIV_JITTER_EN
        if (!(seen4 && seen5)) begin
            failed++;
            $display("FAIL jitter_lengths seen4=%0d seen5=%0d expected 1 1", seen4, seen5);
        end
`else
        if (!(seen4 && !seen5)) begin
            failed++;
            $display("FAIL jitter_lengths seen4=%0d seen5=%0d expected 1 0", seen4, seen5);
        end
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1);
    end

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_reconfig();
        test_clamp();
        test_disable();
        test_indep_reset();
        test_random();
        test_jitter();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
